// File: rtl/sr_mdu_requester.sv
// sr_mdu_requester: CPU-side initiator for the multicycle MDU. It stalls the PC on a MUL,
// issues a single request, waits under a watchdog, and then writes the result back.
module sr_mdu_requester #(
    parameter int timeout_cycles = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_mul,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_srcA,
    input  logic [31:0] cmd_srcB,
    output logic        stall,
    output logic        mdu_i_vld,
    output logic [31:0] mdu_srcA,
    output logic [31:0] mdu_srcB,
    input  logic        mdu_o_vld,
    input  logic [31:0] mdu_result,
    input  logic        mdu_busy,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);
    localparam int CW = $clog2(timeout_cycles + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [31:0]     a_q, b_q, res_q;
    logic [4:0]      rd_q;
    logic            last;

    assign last     = cnt == CW'(timeout_cycles - 1);
    assign mdu_srcA = a_q;
    assign mdu_srcB = b_q;
    assign wb_rd    = rd_q;
    assign wb_data  = res_q;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mdu_i_vld = 1'b0;
        wb_we     = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so that the outputs stay low while reset is held.
                stall     = cmd_mul & rst;
                state_nxt = cmd_mul ? REQ : IDLE;
            end
            REQ: begin
                stall     = 1'b1;
                mdu_i_vld = !mdu_busy;
                state_nxt = mdu_busy ? REQ : WAIT;
            end
            WAIT: begin
                stall     = 1'b1;
                state_nxt = mdu_o_vld ? WB : (last ? IDLE : WAIT);
            end
            WB: begin
                wb_we     = rd_q != 5'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_mul) begin
                a_q  <= cmd_srcA;
                b_q  <= cmd_srcB;
                rd_q <= cmd_rd;
            end
            if (state == REQ) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (state == WAIT && mdu_o_vld) res_q <= mdu_result;
            if (state == WAIT && !mdu_o_vld && last) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sr_mdu_requester.sv
// tb_sr_mdu_requester: table-driven and randomized checks of the MDU requester
// against a transaction-level timing model.
module tb_sr_mdu_requester;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_mul = 1'b0;
    logic [4:0]  cmd_rd = '0;
    logic [31:0] cmd_srcA = '0, cmd_srcB = '0;
    logic        stall, mdu_i_vld, wb_we, timeout_err;
    logic [31:0] mdu_srcA, mdu_srcB, wb_data;
    logic [4:0]  wb_rd;
    logic        mdu_o_vld = 1'b0, mdu_busy = 1'b0;
    logic [31:0] mdu_result = '0;

    int n_tests = 0, n_fail = 0;

    sr_mdu_requester #(.timeout_cycles(T)) dut (
        .clk(clk), .rst(rst), .cmd_mul(cmd_mul), .cmd_rd(cmd_rd),
        .cmd_srcA(cmd_srcA), .cmd_srcB(cmd_srcB), .stall(stall),
        .mdu_i_vld(mdu_i_vld), .mdu_srcA(mdu_srcA), .mdu_srcB(mdu_srcB),
        .mdu_o_vld(mdu_o_vld), .mdu_result(mdu_result), .mdu_busy(mdu_busy),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          d, busy;
        bit          ovreq, pulse;
        int          exp_st, exp_we, exp_wecyc;
        logic [31:0] exp_data;
        logic        exp_to;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one MUL. The TB acts as both the CPU (holding cmd_mul until stall drops,
    // or pulsing it once) and the MDU (answering d cycles after the observed request).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input int d, input int busy_n, input bit ovreq, input bit pulse,
                           output int st_n, output int we_n, output int we_cyc,
                           output int iv_n, output int iv_cyc, output logic [4:0] wrd,
                           output logic [31:0] wdat, output logic [31:0] sa, output logic [31:0] sb);
        bit held = 1'b1;
        st_n = 0; we_n = 0; we_cyc = -1; iv_n = 0; iv_cyc = -1;
        wrd = '0; wdat = '0; sa = '0; sb = '0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            cmd_mul    = (k == 0) || (held && !pulse);
            cmd_srcA   = cmd_mul ? a : $urandom;
            cmd_srcB   = cmd_mul ? b : $urandom;
            cmd_rd     = rd;
            mdu_busy   = k >= 1 && k <= busy_n;
            mdu_o_vld  = (ovreq && k >= 1 && k <= busy_n) || (iv_cyc >= 0 && k == iv_cyc + d);
            mdu_result = (iv_cyc >= 0 && k == iv_cyc + d) ? a * b : $urandom;
            @(negedge clk);
            if (stall) st_n++;
            else if (k > 0) held = 1'b0;
            if (mdu_i_vld) begin
                iv_n++;
                if (iv_cyc < 0) begin
                    iv_cyc = k;
                    sa = mdu_srcA;
                    sb = mdu_srcB;
                end
            end
            if (wb_we) begin
                we_n++;
                we_cyc = k;
                wrd = wb_rd;
                wdat = wb_data;
            end
            if (!held && iv_cyc >= 0 && k > iv_cyc + d + 1) break;
        end
        cmd_mul = 1'b0; mdu_o_vld = 1'b0; mdu_busy = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        int st_n, we_n, we_cyc, iv_n, iv_cyc;
        logic [4:0]  wrd;
        logic [31:0] wdat, sa, sb;
        run_mul(v.a, v.b, v.rd, v.d, v.busy, v.ovreq, v.pulse,
                st_n, we_n, we_cyc, iv_n, iv_cyc, wrd, wdat, sa, sb);
        check({tag, " stall_cycles"}, st_n, v.exp_st);
        check({tag, " wb_we_count"}, we_n, v.exp_we);
        check({tag, " i_vld_count"}, iv_n, 1);
        check({tag, " i_vld_cycle"}, iv_cyc, 1 + v.busy);
        check({tag, " srcA"}, sa, v.a);
        check({tag, " srcB"}, sb, v.b);
        check({tag, " timeout_err"}, {31'd0, timeout_err}, {31'd0, v.exp_to});
        if (v.exp_we != 0) begin
            check({tag, " wb_cycle"}, we_cyc, v.exp_wecyc);
            check({tag, " wb_rd"}, {27'd0, wrd}, {27'd0, v.rd});
            check({tag, " wb_data"}, wdat, v.exp_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctrl"}, {28'd0, stall, mdu_i_vld, wb_we, timeout_err}, 32'd0);
        check({tag, " data"}, mdu_srcA | mdu_srcB | wb_data | {27'd0, wb_rd}, 32'd0);
    endtask

    initial begin
        vec_t tbl[7];
        logic sticky;
        tbl[0] = '{32'd7,  32'd6,  5'd5,  2,  0, 1'b0, 1'b0, 4,  1, 4,  32'd42,  1'b0};
        tbl[1] = '{32'd9,  32'd9,  5'd3,  2,  3, 1'b0, 1'b0, 7,  1, 7,  32'd81,  1'b0};
        tbl[2] = '{32'd3,  32'd3,  5'd0,  2,  0, 1'b0, 1'b0, 4,  0, 0,  32'd9,   1'b0};
        tbl[3] = '{32'd5,  32'd4,  5'd1,  2,  2, 1'b1, 1'b0, 6,  1, 6,  32'd20,  1'b0};
        tbl[4] = '{32'd2,  32'd8,  5'd31, 1,  0, 1'b0, 1'b0, 3,  1, 3,  32'd16,  1'b0};
        tbl[5] = '{32'd10, 32'd10, 5'd7,  16, 0, 1'b0, 1'b0, 18, 1, 18, 32'd100, 1'b0};
        tbl[6] = '{32'd1,  32'd1,  5'd9,  17, 0, 1'b0, 1'b1, 18, 0, 0,  32'd1,   1'b1};

        // Outputs must stay low while reset is held, even with cmd_mul asserted.
        cmd_mul = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        cmd_mul = 1'b0;
        rst = 1'b1;

        // A stray o_vld while idle must be ignored.
        @(posedge clk); #1 mdu_o_vld = 1'b1; mdu_result = 32'hdead;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("idle_ovld", {30'd0, stall, wb_we}, 32'd0);
        end
        mdu_o_vld = 1'b0;

        for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset during WAIT aborts the transaction; a late o_vld must not write.
        @(posedge clk); #1 cmd_mul = 1'b1; cmd_srcA = 32'd4; cmd_srcB = 32'd5; cmd_rd = 5'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk) rst = 1'b1; cmd_mul = 1'b0;
        @(posedge clk); #1 mdu_o_vld = 1'b1; mdu_result = 32'd20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset", {29'd0, stall, wb_we, timeout_err}, 32'd0);
            mdu_o_vld = 1'b0;
        end
        apply(tbl[0], "after_reset");

        // Random transactions against the transaction-level timing model.
        sticky = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.a = $urandom; v.b = $urandom; v.rd = 5'($urandom_range(0, 31));
            v.d = $urandom_range(1, T + 1);
            v.busy = $urandom_range(0, 3);
            v.ovreq = 1'($urandom_range(0, 1));
            v.pulse = v.d > T;
            v.exp_st = (v.d > T ? T : v.d) + 2 + v.busy;
            v.exp_we = (v.d <= T && v.rd != 0) ? 1 : 0;
            v.exp_wecyc = v.d + 2 + v.busy;
            v.exp_data = v.a * v.b;
            sticky = sticky | (v.d > T);
            v.exp_to = sticky;
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end
endmodule
